// File: rtl/router_sync13.sv
// rtl/router_sync13.sv - 1x3 router synchronizer: address latch, write steering, full mux, valid and timeout flush
//
// Optional feature macro: ROUTER_SYNC_ADDR_ERR_EN (adds registered addr_err output)
//
// Ports:
//   clk                     system clock, all state on rising edge
//   resetn                  synchronous reset, asserted high
//   detect_add, data_in     header strobe and destination address to latch
//   write_enb_reg           write request from the router FSM
//   read_enb_0..2           external read strobes per port
//   empty_0..2, full_0..2   FIFO status flags
//   write_enb               one-hot FIFO write enable
//   fifo_full               full flag of the addressed FIFO
//   vld_out_0..2            port has data
//   soft_reset_0..2         one-cycle flush pulse after TIMEOUT idle cycles
//   addr_err                (optional) last header carried address 3
module router_sync13 #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    output logic       addr_err,
`endif
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       addr_reg;
    logic [2:0]       empty_v;
    logic [2:0]       read_v;
    logic [2:0]       full_v;
    logic [2:0]       idle;
    logic [2:0]       soft_reset_q;
    logic [CNT_W-1:0] cnt [3];

    assign empty_v = {empty_2, empty_1, empty_0};
    assign read_v  = {read_enb_2, read_enb_1, read_enb_0};
    assign full_v  = {full_2, full_1, full_0};

    // A port is idle when it holds data that nobody reads this cycle.
    assign idle = ~empty_v & ~read_v;

    always_ff @(posedge clk) begin
        if (resetn) begin
            addr_reg <= 2'b11;
        end else if (detect_add) begin
            addr_reg <= data_in;
        end
    end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
    always_ff @(posedge clk) begin
        if (resetn) begin
            addr_err <= 1'b0;
        end else if (detect_add) begin
            addr_err <= (data_in == 2'b11);
        end
    end
`endif

    // Per-port timeout: the counter restarts on any non-idle edge and also
    // after it fires, so a still-full FIFO gets a fresh window, never a
    // back-to-back pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (resetn || !idle[i]) begin
                cnt[i]          <= '0;
                soft_reset_q[i] <= 1'b0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt[i]          <= '0;
                soft_reset_q[i] <= 1'b1;
            end else begin
                cnt[i]          <= cnt[i] + 1'b1;
                soft_reset_q[i] <= 1'b0;
            end
        end
    end

    assign soft_reset_0 = soft_reset_q[0];
    assign soft_reset_1 = soft_reset_q[1];
    assign soft_reset_2 = soft_reset_q[2];

    // Steering follows the registered address, so a header arriving with a
    // write in the same cycle still writes to the previous destination.
    always_comb begin
        write_enb = 3'b000;
        if (write_enb_reg && addr_reg != 2'b11) begin
            write_enb[addr_reg] = 1'b1;
        end
    end

    always_comb begin
        fifo_full = 1'b0;
        if (addr_reg != 2'b11) begin
            fifo_full = full_v[addr_reg];
        end
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

endmodule
